// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants, state encoding and address helper for the cache block fill responder.
package cache_fill_fsm_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned OFFSET_BITS = 4;
    localparam int unsigned WORD_STEP   = 2;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Byte address of word idx within the block starting at base.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'(idx) * ADDR_W'(WORD_STEP);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Block word counter: sync clear, increment enable, terminal flag at BLOCK_WORDS.
module cache_fill_fsm_word_counter
    import cache_fill_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done_c
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done_c = (count == CNT_W'(BLOCK_WORDS));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill responder: fetches one block word by word and writes data then tag arrays.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_block_addr
);

    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              issue_done_c;
    logic              recv_done_c;
    logic              in_fill_c;
    logic              start_c;
    logic              clear_c;
    logic              accept_c;
    logic              last_c;

    assign in_fill_c = (state == ST_FILL);
    assign start_c   = !in_fill_c && miss_detected;
    assign clear_c   = rst || start_c;

    // A returned word is only taken when a request is still outstanding.
    assign accept_c = in_fill_c && memory_data_valid && !recv_done_c && (recv_cnt < issue_cnt);
    assign last_c   = accept_c && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));

    cache_fill_fsm_word_counter u_issue_cnt (
        .clk    (clk),
        .clear  (clear_c),
        .inc    (mem_enable),
        .count  (issue_cnt),
        .done_c (issue_done_c)
    );

    cache_fill_fsm_word_counter u_recv_cnt (
        .clk    (clk),
        .clear  (clear_c),
        .inc    (accept_c),
        .count  (recv_cnt),
        .done_c (recv_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            base  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_detected) begin
                        base  <= miss_address & BLOCK_MASK;
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (last_c) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Requester-facing strobes follow the registered state within the same cycle.
    always_comb begin
        fsm_busy         = in_fill_c || start_c;
        mem_enable       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_addr        = '0;
        fill_data        = memory_data;
        write_tag_array  = 1'b0;
        fill_block_addr  = '0;
        if (in_fill_c) begin
            mem_enable       = !issue_done_c;
            memory_address   = issue_done_c ? '0 : word_addr(base, issue_cnt);
            write_data_array = accept_c;
            fill_addr        = accept_c ? word_addr(base, recv_cnt) : '0;
            write_tag_array  = last_c;
            fill_block_addr  = base;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: vector table, directed fills and randomized fills.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [15:0] fill_block_addr;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_enable        (mem_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_block_addr   (fill_block_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        men;
        logic [15:0] maddr;
        logic        wr;
        logic [15:0] faddr;
        logic        tag;
        logic [15:0] fba;
    } exp_t;

    typedef struct {
        logic        r;
        logic        m;
        logic [15:0] ma;
        logic        v;
        logic [15:0] d;
        bit          chk;
        exp_t        e;
    } vec_t;

    int        total;
    int        bad;
    int        cyc;
    int        lat;
    bit [63:0] pend;   // memory model: a return is due on cycle index (mod 64)

    function automatic exp_t ex(input logic busy, input logic men, input logic [15:0] maddr,
                                input logic wr, input logic [15:0] faddr, input logic tag,
                                input logic [15:0] fba);
        exp_t e;
        e.busy = busy; e.men = men; e.maddr = maddr; e.wr = wr;
        e.faddr = faddr; e.tag = tag; e.fba = fba;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        return ex(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endfunction

    // Closed-form expectation for cycle t of a fill of block b with memory latency l.
    function automatic exp_t fill_exp(input logic [15:0] b, input int l, input int t);
        exp_t e;
        e.busy  = 1'b1;
        e.men   = (t >= 1) && (t <= 8);
        e.maddr = e.men ? b + 16'(2 * (t - 1)) : 16'h0;
        e.wr    = (t >= 1 + l) && (t <= 8 + l);
        e.faddr = e.wr ? b + 16'(2 * (t - 1 - l)) : 16'h0;
        e.tag   = (t == 8 + l);
        e.fba   = (t >= 1) ? b : 16'h0;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, then let memory observe requests.
    task automatic step(input logic r, input logic m, input logic [15:0] ma, input bit use_mem,
                        input logic fv, input logic [15:0] fd, input bit chk, input exp_t e);
        logic        v;
        logic [15:0] d;
        @(negedge clk);
        v = use_mem ? pend[cyc % 64] : fv;
        d = use_mem ? 16'($urandom) : fd;
        pend[cyc % 64] = 1'b0;
        rst               = r;
        miss_detected     = m;
        miss_address      = ma;
        memory_data_valid = v;
        memory_data       = d;
        #1;
        if (chk) begin
            cmp("busy", 32'(fsm_busy), 32'(e.busy));
            cmp("mem_enable", 32'(mem_enable), 32'(e.men));
            if (e.men || !e.busy) cmp("memory_address", 32'(memory_address), 32'(e.maddr));
            cmp("write_data", 32'(write_data_array), 32'(e.wr));
            if (e.wr || !e.busy) cmp("fill_addr", 32'(fill_addr), 32'(e.faddr));
            cmp("fill_data", 32'(fill_data), 32'(d));
            cmp("write_tag", 32'(write_tag_array), 32'(e.tag));
            cmp("fill_block_addr", 32'(fill_block_addr), 32'(e.fba));
        end
        if (use_mem && mem_enable === 1'b1) pend[(cyc + lat) % 64] = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit spur);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 16'($urandom), !spur, 1'b1, 16'($urandom), 1'b1, idle_exp());
    endtask

    // Full fill of the block holding a; optional re-miss at remiss_t and reset at rst_t.
    task automatic run_fill(input logic [15:0] a, input int l, input int remiss_t,
                            input logic [15:0] remiss_a, input int rst_t);
        logic [15:0] b;
        lat = l;
        b   = a & 16'hFFF0;
        for (int t = 0; t <= 8 + l; t++) begin
            if (t == rst_t) begin
                step(1'b1, 1'b0, a, 1'b1, 1'b0, 16'h0, 1'b0, fill_exp(b, l, t));
                return;
            end
            if (t == 0)
                step(1'b0, 1'b1, a, 1'b1, 1'b0, 16'h0, 1'b1, fill_exp(b, l, t));
            else if (t == remiss_t)
                step(1'b0, 1'b1, remiss_a, 1'b1, 1'b0, 16'h0, 1'b1, fill_exp(b, l, t));
            else
                step(1'b0, 1'b0, 16'($urandom), 1'b1, 1'b0, 16'h0, 1'b1, fill_exp(b, l, t));
        end
    endtask

    vec_t vecs[7];

    initial begin
        total = 0; bad = 0; cyc = 0; lat = 4; pend = '0;
        rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
        memory_data_valid = 1'b0; memory_data = 16'h0;

        vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, idle_exp()};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b1, idle_exp()};
        vecs[2] = '{1'b0, 1'b1, 16'h1236, 1'b0, 16'h0000, 1'b1,
                    ex(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0)};
        vecs[3] = '{1'b0, 1'b0, 16'h1236, 1'b1, 16'h1111, 1'b1,
                    ex(1'b1, 1'b1, 16'h1230, 1'b0, 16'h0, 1'b0, 16'h1230)};
        vecs[4] = '{1'b0, 1'b0, 16'h1236, 1'b1, 16'h2222, 1'b1,
                    ex(1'b1, 1'b1, 16'h1232, 1'b1, 16'h1230, 1'b0, 16'h1230)};
        vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, idle_exp()};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, idle_exp()};

        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, idle_exp());
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, idle_exp());

        for (int i = 0; i < 7; i++)
            step(vecs[i].r, vecs[i].m, vecs[i].ma, 1'b0, vecs[i].v, vecs[i].d,
                 vecs[i].chk, vecs[i].e);

        // Basic fill, then busy must drop.
        run_fill(16'h1236, 4, -1, 16'h0, -1);
        idle(1, 1'b0);
        // Reset at cycle 6: late returns must not write.
        run_fill(16'h1230, 4, -1, 16'h0, 6);
        idle(8, 1'b0);
        idle(2, 1'b1);
        // Re-miss during a fill is ignored.
        run_fill(16'h1234, 4, 3, 16'h4000, -1);
        idle(1, 1'b0);
        // Top of address space, then back-to-back miss.
        run_fill(16'hFFF8, 4, -1, 16'h0, -1);
        run_fill(16'h0010, 4, -1, 16'h0, -1);
        idle(1, 1'b0);
        // Single-cycle memory latency.
        run_fill(16'h2468, 1, -1, 16'h0, -1);
        idle(1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            int l;
            int rt;
            l  = int'($urandom_range(1, 6));
            rt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8 + l)) : -1;
            run_fill(16'($urandom), l,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1,
                     16'($urandom), rt);
            if (rt >= 0)
                idle(10, 1'b0);
            else if ($urandom_range(0, 1) == 1)
                idle(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end
        idle(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
